// File: rtl/gol_sched_pkg.sv
// Shared constants for the Game-of-Life display/update scheduler:
// VGA timing constants and grid defaults plus the scheduler state type.
package defs_vga;
    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_V_ACTIVE = 480;
endpackage

package defs_gol;
    localparam int GOL_GRID_W     = 80;
    localparam int GOL_GRID_H     = 60;
    localparam int GOL_CELL_SHIFT = 3;

    typedef enum logic [1:0] {
        IDLE,
        START,
        RUN,
        SWAP_WAIT
    } gol_state_t;
endpackage

// File: rtl/gol_sched_if.sv
// Engine handshake and cell-RAM port bundle between the scheduler (master)
// and the update engine / RAM side (slave).
interface gol_sched_if #(
    parameter int ADDR_W = $clog2(defs_gol::GOL_GRID_W * defs_gol::GOL_GRID_H)
) ();
    logic              o_eng_start;
    logic              i_eng_done;
    logic              i_eng_req;
    logic              i_eng_we;
    logic [ADDR_W-1:0] i_eng_addr;
    logic              o_eng_gnt;
    logic [ADDR_W:0]   o_mem_addr;
    logic              o_mem_we;
    logic              i_mem_rdata;

    modport master (
        output o_eng_start, o_eng_gnt, o_mem_addr, o_mem_we,
        input  i_eng_done, i_eng_req, i_eng_we, i_eng_addr, i_mem_rdata
    );

    modport slave (
        input  o_eng_start, o_eng_gnt, o_mem_addr, o_mem_we,
        output i_eng_done, i_eng_req, i_eng_we, i_eng_addr, i_mem_rdata
    );
endinterface

// File: rtl/gol_frame_tick.sv
// End-of-frame pulse from the VGA active flag, plus the frames-per-generation
// divider that runs on every frame end while free-running is enabled.
module gol_frame_tick #(
    parameter int SPEED_W = 4,
    parameter int Y_W     = $clog2(defs_vga::VGA_V_ACTIVE)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_draw_active,
    input  logic [Y_W-1:0]     i_active_y,
    input  logic               i_run,
    input  logic [SPEED_W-1:0] i_speed,
    output logic               o_frame_end,
    output logic               o_div_hit
);
    import defs_vga::*;

    localparam logic [Y_W-1:0] LAST_Y = Y_W'(VGA_V_ACTIVE - 1);

    logic               draw_q;
    logic [Y_W-1:0]     y_q;
    logic [SPEED_W-1:0] frame_cnt;

    assign o_div_hit = o_frame_end & (frame_cnt == i_speed);

    // Divider keeps counting while a generation is in flight so the cadence
    // stays at i_speed+1 frames regardless of how long the swap takes.
    always_ff @(posedge clk) begin
        if (rst) begin
            draw_q      <= 1'b0;
            y_q         <= '0;
            o_frame_end <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            draw_q      <= i_draw_active;
            y_q         <= i_active_y;
            o_frame_end <= draw_q & ~i_draw_active & (y_q == LAST_Y);
            if (i_run && o_frame_end)
                frame_cnt <= o_div_hit ? '0 : frame_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/gol_sched.sv
// Arbitrates the double-buffered cell RAM between VGA display reads and the
// update engine, and sequences generations (start, run, buffer swap).
module gol_sched
    import defs_gol::*;
    import defs_vga::*;
#(
    parameter int GRID_W     = GOL_GRID_W,
    parameter int GRID_H     = GOL_GRID_H,
    parameter int CELL_SHIFT = GOL_CELL_SHIFT,
    parameter int SPEED_W    = 4,
    localparam int ADDR_W    = $clog2(GRID_W * GRID_H),
    localparam int X_W       = $clog2(VGA_H_ACTIVE),
    localparam int Y_W       = $clog2(VGA_V_ACTIVE)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_draw_active,
    input  logic [X_W-1:0]     i_active_x,
    input  logic [Y_W-1:0]     i_active_y,
    input  logic               i_run,
    input  logic               i_step,
    input  logic [SPEED_W-1:0] i_speed,
    gol_sched_if.master        bus,
    output logic               o_pix_on,
    output logic               o_pix_valid,
    output logic               o_front,
    output logic               o_frame_end,
    output logic               o_busy,
    output logic [15:0]        o_gen_count
);
    localparam logic [X_W-1:0] GRID_W_X = X_W'(GRID_W);
    localparam logic [Y_W-1:0] GRID_H_Y = Y_W'(GRID_H);

    gol_state_t state, state_nxt;

    logic              step_pend;
    logic              div_hit;
    logic              go;
    logic              swap;
    logic              gnt;
    logic              rd_q;
    logic [X_W-1:0]    cell_x;
    logic [Y_W-1:0]    cell_y;
    logic              disp_rd;
    logic [ADDR_W-1:0] cell_addr;

    gol_frame_tick #(
        .SPEED_W (SPEED_W),
        .Y_W     (Y_W)
    ) u_tick (
        .clk           (clk),
        .rst           (rst),
        .i_draw_active (i_draw_active),
        .i_active_y    (i_active_y),
        .i_run         (i_run),
        .i_speed       (i_speed),
        .o_frame_end   (o_frame_end),
        .o_div_hit     (div_hit)
    );

    assign cell_x    = i_active_x >> CELL_SHIFT;
    assign cell_y    = i_active_y >> CELL_SHIFT;
    assign disp_rd   = i_draw_active & (cell_x < GRID_W_X) & (cell_y < GRID_H_Y);
    assign cell_addr = ADDR_W'(cell_y) * ADDR_W'(GRID_W) + ADDR_W'(cell_x);

    always_comb begin
        state_nxt       = state;
        bus.o_eng_start = 1'b0;
        go              = 1'b0;
        swap            = 1'b0;
        case (state)
            IDLE: begin
                if (o_frame_end && (i_run ? div_hit : step_pend)) begin
                    go        = 1'b1;
                    state_nxt = START;
                end
            end
            START: begin
                bus.o_eng_start = 1'b1;
                state_nxt       = RUN;
            end
            RUN: begin
                if (bus.i_eng_done) begin
                    if (o_frame_end) begin
                        swap      = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = SWAP_WAIT;
                    end
                end
            end
            SWAP_WAIT: begin
                if (o_frame_end) begin
                    swap      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            step_pend   <= 1'b0;
            o_front     <= 1'b0;
            o_gen_count <= '0;
        end else begin
            state     <= state_nxt;
            step_pend <= go ? 1'b0 : (step_pend | (i_step & ~i_run));
            if (swap) begin
                o_front     <= ~o_front;
                o_gen_count <= o_gen_count + 16'd1;
            end
        end
    end

    assign o_busy = (state != IDLE);

    // Display owns the RAM whenever the beam is active; the engine writes the
    // back buffer and reads the front one.
    always_comb begin
        gnt            = bus.i_eng_req & ~i_draw_active & (state == RUN);
        bus.o_eng_gnt  = gnt;
        bus.o_mem_we   = 1'b0;
        bus.o_mem_addr = '0;
        if (disp_rd) begin
            bus.o_mem_addr = {o_front, cell_addr};
        end else if (gnt) begin
            bus.o_mem_we   = bus.i_eng_we;
            bus.o_mem_addr = {bus.i_eng_we ? ~o_front : o_front, bus.i_eng_addr};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q        <= 1'b0;
            o_pix_valid <= 1'b0;
            o_pix_on    <= 1'b0;
        end else begin
            rd_q        <= disp_rd;
            o_pix_valid <= rd_q;
            o_pix_on    <= rd_q & bus.i_mem_rdata;
        end
    end
endmodule

// File: tb/tb_gol_sched.sv
// Randomised and directed bench for gol_sched with a cycle-level behavioural
// model of frame timing, generation sequencing and RAM arbitration.
module tb_gol_sched;
    logic        clk = 1'b0;
    logic        rst;
    logic        da;
    logic [9:0]  ax;
    logic [8:0]  ay;
    logic        run;
    logic        step;
    logic [3:0]  speed;
    logic        pix_on, pix_valid, front, frame_end, busy;
    logic [15:0] gen_count;

    gol_sched_if #(.ADDR_W(13)) bus ();

    gol_sched dut (
        .clk           (clk),
        .rst           (rst),
        .i_draw_active (da),
        .i_active_x    (ax),
        .i_active_y    (ay),
        .i_run         (run),
        .i_step        (step),
        .i_speed       (speed),
        .bus           (bus),
        .o_pix_on      (pix_on),
        .o_pix_valid   (pix_valid),
        .o_front       (front),
        .o_frame_end   (frame_end),
        .o_busy        (busy),
        .o_gen_count   (gen_count)
    );

    always #5 clk = ~clk;

    bit ram [0:16383];
    always @(posedge clk) bus.i_mem_rdata <= ram[bus.o_mem_addr];

    int n_checks = 0;
    int n_errors = 0;
    int n_starts = 0;

    // model state
    bit m_fe, m_prev_da, m_step_pend, m_kick, m_eng, m_swap_due, m_front;
    int m_prev_y, m_fcnt, m_gen;
    bit p1_v, p2_v;
    int p1_a, p2_a;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input bit rd, input int addr);
        bit hit, go, swap, nsd, neng;
        if (rst) begin
            m_fe = 0; m_prev_da = 0; m_prev_y = 0; m_fcnt = 0; m_step_pend = 0;
            m_kick = 0; m_eng = 0; m_swap_due = 0; m_front = 0; m_gen = 0;
            p1_v = 0; p2_v = 0; p1_a = 0; p2_a = 0;
            return;
        end
        hit = 0;
        if (m_fe && run) begin
            hit    = (m_fcnt == int'(speed));
            m_fcnt = hit ? 0 : (m_fcnt + 1) % 16;
        end
        go   = !(m_kick || m_eng || m_swap_due) && m_fe && (run ? hit : m_step_pend);
        swap = m_fe && ((m_eng && bus.i_eng_done) || m_swap_due);
        nsd  = !m_fe && ((m_eng && bus.i_eng_done) || m_swap_due);
        neng = m_kick || (m_eng && !bus.i_eng_done);
        m_step_pend = go ? 1'b0 : (m_step_pend || (step && !run));
        m_kick = go; m_eng = neng; m_swap_due = nsd;
        if (swap) begin
            m_front = !m_front;
            m_gen   = (m_gen + 1) % 65536;
        end
        p2_v = p1_v; p2_a = p1_a; p1_v = rd; p1_a = addr;
        m_fe = m_prev_da && !da && (m_prev_y == 479);
        m_prev_da = da;
        m_prev_y  = int'(ay);
    endtask

    task automatic cycle();
        int cx, cy, exp_addr;
        bit rd, g;
        #1;
        cx = int'(ax) / 8;
        cy = int'(ay) / 8;
        rd = da && cx < 80 && cy < 60;
        g  = m_eng && !da && bus.i_eng_req;
        if (rd)
            exp_addr = int'(m_front) * 8192 + cy * 80 + cx;
        else if (g)
            exp_addr = int'(bus.i_eng_we ? !m_front : m_front) * 8192 + int'(bus.i_eng_addr);
        else
            exp_addr = 0;
        check("frame_end", frame_end, m_fe);
        check("eng_start", bus.o_eng_start, m_kick);
        check("busy", busy, m_kick || m_eng || m_swap_due);
        check("front", front, m_front);
        check("gen_count", gen_count, m_gen);
        check("eng_gnt", bus.o_eng_gnt, g);
        check("mem_we", bus.o_mem_we, g && bus.i_eng_we);
        check("mem_addr", bus.o_mem_addr, exp_addr);
        check("pix_valid", pix_valid, p2_v);
        check("pix_on", pix_on, p2_v && ram[p2_a]);
        if (bus.o_eng_start) n_starts++;
        @(posedge clk);
        model_step(rd, exp_addr);
        @(negedge clk);
    endtask

    task automatic frame();
        da = 1; ay = 9'd479; ax = '0;
        cycle();
        da = 0;
        repeat (5) cycle();
    endtask

    task automatic do_reset();
        rst = 1; cycle(); rst = 0;
    endtask

    task automatic one_gen();
        step = 1; cycle(); step = 0;
        frame();
        bus.i_eng_done = 1; cycle(); bus.i_eng_done = 0;
        frame();
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) ram[i] = 1'($urandom_range(0, 1));
        da = 0; ax = '0; ay = '0; run = 0; step = 0; speed = '0;
        bus.i_eng_done = 0; bus.i_eng_req = 0; bus.i_eng_we = 0; bus.i_eng_addr = '0;
        rst = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 0;

        // display read at (17,9) with a competing engine request
        da = 1; ax = 10'd17; ay = 9'd9; bus.i_eng_req = 1;
        #1;
        check("disp_addr", bus.o_mem_addr, 82);
        check("disp_gnt", bus.o_eng_gnt, 0);
        check("disp_we", bus.o_mem_we, 0);
        cycle();
        da = 0; bus.i_eng_req = 0;
        cycle();
        #1 check("disp_valid_lat2", pix_valid, 1);

        // free-run, speed 2, engine finishes at once
        do_reset();
        n_starts = 0; run = 1; speed = 4'd2; bus.i_eng_done = 1;
        repeat (9) frame();
        check("div3_starts", n_starts, 3);

        // single step, plus engine write grant while running
        run = 0; bus.i_eng_done = 0;
        do_reset();
        n_starts = 0;
        step = 1; cycle(); step = 0;
        frame();
        da = 0; bus.i_eng_req = 1; bus.i_eng_we = 1; bus.i_eng_addr = 13'd100;
        #1;
        check("eng_gnt_run", bus.o_eng_gnt, 1);
        check("eng_wr_addr", bus.o_mem_addr, 8192 + 100);
        check("eng_wr_we", bus.o_mem_we, 1);
        cycle();
        bus.i_eng_req = 0; bus.i_eng_we = 0; bus.i_eng_addr = '0;
        bus.i_eng_done = 1; cycle(); bus.i_eng_done = 0;
        frame();
        frame();
        check("step_starts", n_starts, 1);
        check("step_front", front, 1);
        check("step_gen", gen_count, 1);

        // done coincident with frame end
        step = 1; cycle(); step = 0;
        frame();
        da = 1; ay = 9'd479; cycle();
        da = 0; cycle();
        bus.i_eng_done = 1;
        #1 check("coinc_fe", frame_end, 1);
        cycle();
        bus.i_eng_done = 0;
        check("coinc_front", front, 0);
        check("coinc_gen", gen_count, 2);
        check("coinc_idle", busy, 0);

        // reset in the middle of a generation
        repeat (3) one_gen();
        step = 1; cycle(); step = 0;
        frame();
        check("pre_rst_busy", busy, 1);
        check("pre_rst_front", front, 1);
        check("pre_rst_gen", gen_count, 5);
        do_reset();
        check("rst_front", front, 0);
        check("rst_gen", gen_count, 0);
        check("rst_busy", busy, 0);
        check("rst_start", bus.o_eng_start, 0);
        check("rst_valid", pix_valid, 0);
        check("rst_fe", frame_end, 0);

        // random traffic
        repeat (3000) begin
            rst   = ($urandom_range(0, 399) == 0);
            da    = 1'($urandom_range(0, 1));
            ax    = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(640, 1023))
                                                : 10'($urandom_range(0, 639));
            ay    = ($urandom_range(0, 2) == 0) ? 9'd479 : 9'($urandom_range(0, 511));
            if ($urandom_range(0, 63) == 0) run = ~run;
            step  = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 99) == 0) speed = 4'($urandom_range(0, 3));
            bus.i_eng_done = ($urandom_range(0, 5) == 0);
            bus.i_eng_req  = 1'($urandom_range(0, 1));
            bus.i_eng_we   = 1'($urandom_range(0, 1));
            bus.i_eng_addr = 13'($urandom_range(0, 4799));
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/gol_sched.md
GOL_SCHED -- requirements
Module: gol_sched

Interface
REQ-001 The block SHALL have parameter GRID_W, default 80, grid width in cells.
REQ-002 The block SHALL have parameter GRID_H, default 60, grid height in cells.
REQ-003 The block SHALL have parameter CELL_SHIFT, default 3, log2 of cell edge in pixels.
REQ-004 The block SHALL have parameter SPEED_W, default 4, width of i_speed; ADDR_W SHALL be $clog2(GRID_W*GRID_H).
REQ-005 The block SHALL have one clock and a synchronous, active-high reset.
REQ-006 clk  in  1  sole clock; rst  in  1  synchronous active-high reset.
REQ-007 i_draw_active  in  1  VGA active-region flag.
REQ-008 i_active_x, i_active_y  in  $clog2(VGA_H_ACTIVE) / $clog2(VGA_V_ACTIVE)  VGA pixel coordinates.
REQ-009 i_run  in  1  level, free-run generations; i_step  in  1  pulse, one generation while paused.
REQ-010 i_speed  in  SPEED_W  frames per generation minus one.
REQ-011 o_eng_start  out  1  one-cycle start pulse to update engine; i_eng_done  in  1  engine finished pulse.
REQ-012 i_eng_req  in  1; i_eng_we  in  1; i_eng_addr  in  ADDR_W  engine RAM access request; o_eng_gnt  out  1  grant.
REQ-013 o_mem_addr  out  ADDR_W+1  RAM address, MSB = buffer; o_mem_we  out  1; i_mem_rdata  in  1  RAM data, 1-cycle read latency.
REQ-014 o_pix_on  out  1; o_pix_valid  out  1  display cell state; o_front  out  1  displayed buffer; o_frame_end  out  1; o_busy  out  1; o_gen_count  out  16.

Function
REQ-015 o_frame_end SHALL pulse one cycle after i_draw_active falls while registered i_active_y equals VGA_V_ACTIVE-1.
REQ-016 Display read SHALL occur when i_draw_active=1 and (x>>CELL_SHIFT)<GRID_W and (y>>CELL_SHIFT)<GRID_H: o_mem_addr={o_front, (y>>CELL_SHIFT)*GRID_W+(x>>CELL_SHIFT)}, o_mem_we=0.
REQ-017 Display SHALL have absolute priority; o_eng_gnt SHALL be 0 during any cycle with i_draw_active=1.
REQ-018 o_eng_gnt SHALL equal i_eng_req when i_draw_active=0 and state is RUN, else 0, combinationally.
REQ-019 Granted engine writes SHALL address {~o_front, i_eng_addr} with o_mem_we=1; granted reads SHALL address {o_front, i_eng_addr}.
REQ-020 o_pix_valid SHALL follow a display read by exactly 2 cycles; o_pix_on SHALL be i_mem_rdata registered, 0 for out-of-grid active pixels.
REQ-021 FSM states IDLE, START, RUN, SWAP_WAIT; o_busy=1 outside IDLE.
REQ-022 IDLE: on o_frame_end with i_run=1, frame counter==i_speed -> START and counter cleared, else counter increments.
REQ-023 IDLE: with i_run=0 and step pending, on o_frame_end -> START; i_step pulses latch step pending, cleared on entering START; i_step ignored while i_run=1.
REQ-024 START: o_eng_start=1 for one cycle -> RUN.
REQ-025 RUN: i_eng_done -> SWAP_WAIT; if i_eng_done coincides with o_frame_end, swap immediately and -> IDLE.
REQ-026 SWAP_WAIT: on o_frame_end, o_front toggles, o_gen_count increments (wrapping at 2^16), -> IDLE.
REQ-027 i_eng_done outside RUN SHALL be ignored; changes to i_speed take effect at the next comparison.

Reset
REQ-028 On rst: state IDLE, frame counter 0, step pending 0, o_front=0, o_gen_count=0, all pulse/valid outputs 0, pipeline registers cleared, including mid-RUN.

Structure
REQ-029 GRID_W, GRID_H, CELL_SHIFT defaults and the FSM state enum SHALL live in shared package defs_gol; VGA constants come from defs_vga.
REQ-030 Frame-end detection and frame divider SHALL be sub-module gol_frame_tick.

Verification
REQ-031 x=17, y=9, draw_active=1, eng_req=1 -> o_mem_addr={0,82}, we=0, o_eng_gnt=0; o_pix_valid 2 cycles later.
REQ-032 RUN, draw_active=0, eng_req=1, we=1, addr=100 -> o_eng_gnt=1, o_mem_addr={1,100}, o_mem_we=1.
REQ-033 i_run=1, i_speed=2, engine done immediately -> o_eng_start after every 3rd o_frame_end.
REQ-034 i_run=0, one i_step -> exactly one o_eng_start; after done+frame_end o_front=1, o_gen_count=1.
REQ-035 i_eng_done coincident with o_frame_end -> o_front toggles next cycle, state IDLE.
REQ-036 rst asserted in RUN with o_front=1, o_gen_count=5 -> next cycle all outputs zero, IDLE.
